// File: rtl/controle_batalha_naval_pkg.sv
// Shared definitions for the naval-battle game controller: FSM state encoding
// and winner codes.
package controle_batalha_naval_pkg;

    typedef enum logic [1:0] {
        ESPERA_J1 = 2'd0,
        ESPERA_J2 = 2'd1,
        AVALIA    = 2'd2,
        FIM       = 2'd3
    } estado_t;

    localparam logic VENC_J1 = 1'b0;
    localparam logic VENC_J2 = 1'b1;

endpackage

// File: rtl/controle_batalha_naval_contador.sv
// Attempt counter for the game controller: synchronous clear has priority over
// the count enable. The reset is asynchronous.
module contador_tentativas #(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] q
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values and simulation ordering cannot change the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + CW'(1);
        end
    end

endmodule

// File: rtl/controle_batalha_naval.sv
// Naval-battle game controller: captures the secret, accepts guesses, evaluates
// the external comparator's hit flag and holds the winner until a new game.
module controle_batalha_naval
    import controle_batalha_naval_pkg::*;
#(
    parameter int unsigned W        = 3,
    parameter int unsigned MAX_TENT = 4,
    parameter int unsigned CW       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          novo_jogo,
    input  logic          j1_valid,
    input  logic [W-1:0]  j1_dado,
    output logic          j1_ready,
    input  logic          j2_valid,
    input  logic [W-1:0]  j2_dado,
    output logic          j2_ready,
    input  logic          acerto,
    output logic [W-1:0]  jogada1,
    output logic [W-1:0]  jogada2,
    output logic [CW-1:0] tentativas,
    output logic          fim,
    output logic          vencedor
);

    estado_t estado, prox;
    logic    cap_j1, cap_j2, venc_load, venc_d;

    contador_tentativas #(.CW(CW)) u_contador (
        .clk (clk),
        .rst (rst),
        .clr (novo_jogo),
        .en  (cap_j2),
        .q   (tentativas)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        prox      = estado;
        j1_ready  = 1'b0;
        j2_ready  = 1'b0;
        fim       = 1'b0;
        cap_j1    = 1'b0;
        cap_j2    = 1'b0;
        venc_load = 1'b0;
        venc_d    = VENC_J1;
        case (estado)
            ESPERA_J1: begin
                j1_ready = 1'b1;
                if (j1_valid) begin
                    cap_j1 = 1'b1;
                    prox   = ESPERA_J2;
                end
            end
            ESPERA_J2: begin
                j2_ready = 1'b1;
                if (j2_valid) begin
                    cap_j2 = 1'b1;
                    prox   = AVALIA;
                end
            end
            AVALIA: begin
                if (acerto) begin
                    prox      = FIM;
                    venc_load = 1'b1;
                    venc_d    = VENC_J2;
                end else if (tentativas == CW'(MAX_TENT)) begin
                    prox      = FIM;
                    venc_load = 1'b1;
                    venc_d    = VENC_J1;
                end else begin
                    prox = ESPERA_J2;
                end
            end
            FIM:     fim  = 1'b1;
            default: prox = ESPERA_J1;
        endcase
        // Restart wins over any transfer offered in the same cycle; ready stays
        // a function of state alone.
        if (novo_jogo) begin
            prox      = ESPERA_J1;
            cap_j1    = 1'b0;
            cap_j2    = 1'b0;
            venc_load = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado   <= ESPERA_J1;
            jogada1  <= '0;
            jogada2  <= '0;
            vencedor <= VENC_J1;
        end else begin
            estado <= prox;
            if (cap_j1) jogada1 <= j1_dado;
            if (novo_jogo)   jogada2 <= '0;
            else if (cap_j2) jogada2 <= j2_dado;
            if (novo_jogo)      vencedor <= VENC_J1;
            else if (venc_load) vencedor <= venc_d;
        end
    end

endmodule

// File: tb/tb_controle_batalha_naval.sv
// Self-checking bench for controle_batalha_naval: directed scenarios plus
// randomized games scored against a per-game reference model.
module tb_controle_batalha_naval;

    localparam int W        = 3;
    localparam int MAX_TENT = 4;
    localparam int CW       = 3;

    typedef struct {
        logic         venc;
        logic [CW-1:0] tent;
    } resultado_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          novo_jogo;
    logic          j1_valid, j2_valid;
    logic [W-1:0]  j1_dado, j2_dado;
    logic          j1_ready, j2_ready;
    logic          acerto;
    logic [W-1:0]  jogada1, jogada2;
    logic [CW-1:0] tentativas;
    logic          fim, vencedor;

    int passed = 0;
    int total  = 0;
    resultado_t esperado[$];
    logic fim_prev = 1'b0;

    controle_batalha_naval #(.W(W), .MAX_TENT(MAX_TENT), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .novo_jogo  (novo_jogo),
        .j1_valid   (j1_valid),
        .j1_dado    (j1_dado),
        .j1_ready   (j1_ready),
        .j2_valid   (j2_valid),
        .j2_dado    (j2_dado),
        .j2_ready   (j2_ready),
        .acerto     (acerto),
        .jogada1    (jogada1),
        .jogada2    (jogada2),
        .tentativas (tentativas),
        .fim        (fim),
        .vencedor   (vencedor)
    );

    // Stand-in for the downstream hit comparator.
    assign acerto = (jogada1 == jogada2);

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    // Monitor: every rising edge of fim completes one game from the scoreboard.
    always @(negedge clk) begin
        if (fim && !fim_prev) begin
            if (esperado.size() == 0) begin
                check("unexpected_fim", 32'd1, 32'd0);
            end else begin
                resultado_t r;
                r = esperado.pop_front();
                check("sb_vencedor", 32'(vencedor), 32'(r.venc));
                check("sb_tentativas", 32'(tentativas), 32'(r.tent));
            end
        end
        fim_prev <= fim;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic novo();
        novo_jogo = 1'b1;
        tick();
        novo_jogo = 1'b0;
    endtask

    task automatic send_j1(input logic [W-1:0] d);
        int n = 0;
        logic ok;
        j1_valid = 1'b1;
        j1_dado  = d;
        do begin
            ok = j1_ready;
            tick();
            n++;
        end while (!ok && n < 20);
        j1_valid = 1'b0;
        if (!ok) check("j1_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_j2(input logic [W-1:0] d);
        int n = 0;
        logic ok;
        j2_valid = 1'b1;
        j2_dado  = d;
        do begin
            ok = j2_ready;
            tick();
            n++;
        end while (!ok && n < 20);
        j2_valid = 1'b0;
        if (!ok) check("j2_accept_timeout", 32'd0, 32'd1);
    endtask

    // Flip both valids mid-cycle; ready must not move.
    task automatic check_ready_indep();
        logic r1, r2;
        r1 = j1_ready;
        r2 = j2_ready;
        j1_valid = ~j1_valid;
        j2_valid = ~j2_valid;
        #1;
        check("j1_ready_indep", 32'(j1_ready), 32'(r1));
        check("j2_ready_indep", 32'(j2_ready), 32'(r2));
        j1_valid = ~j1_valid;
        j2_valid = ~j2_valid;
        #1;
    endtask

    initial begin
        logic [W-1:0] secreto;
        logic [W-1:0] palpite[MAX_TENT];
        int acertou, n, espera;

        rst = 1'b1; novo_jogo = 1'b0;
        j1_valid = 1'b0; j2_valid = 1'b0; j1_dado = '0; j2_dado = '0;
        tick(); tick();
        check("rst_j1_ready", 32'(j1_ready), 32'd1);
        check("rst_j2_ready", 32'(j2_ready), 32'd0);
        check("rst_fim", 32'(fim), 32'd0);
        check("rst_tentativas", 32'(tentativas), 32'd0);
        rst = 1'b0;
        tick();

        // Hit on the second guess; fim appears one edge after the AVALIA edge.
        esperado.push_back('{venc: 1'b1, tent: CW'(2)});
        send_j1(3'b000);
        send_j2(3'b001);
        send_j2(3'b000);
        check("t2_fim_in_avalia", 32'(fim), 32'd0);
        check("t2_tent_after_accept", 32'(tentativas), 32'd2);
        tick();
        check("t2_fim", 32'(fim), 32'd1);
        check("t2_vencedor", 32'(vencedor), 32'd1);
        check("t2_tentativas", 32'(tentativas), 32'd2);
        novo();

        // Four misses: player 1 wins, a fifth guess is refused.
        esperado.push_back('{venc: 1'b0, tent: CW'(4)});
        send_j1(3'b101);
        for (int i = 0; i < 4; i++) send_j2(W'(i));
        tick();
        check("t3_fim", 32'(fim), 32'd1);
        check("t3_vencedor", 32'(vencedor), 32'd0);
        j2_valid = 1'b1; j2_dado = 3'b111;
        check("t3_j2_ready_in_fim", 32'(j2_ready), 32'd0);
        tick(); tick();
        j2_valid = 1'b0;
        check("t3_tentativas_held", 32'(tentativas), 32'd4);
        check("t3_jogada2_held", 32'(jogada2), 32'd3);
        novo();
        check("novo_clears_fim", 32'(fim), 32'd0);
        check("novo_clears_venc", 32'(vencedor), 32'd0);
        check("novo_keeps_jogada1", 32'(jogada1), 32'h5);

        // Both valids in ESPERA_J1: only the secret is taken.
        j1_valid = 1'b1; j1_dado = 3'b011;
        j2_valid = 1'b1; j2_dado = 3'b011;
        tick();
        j1_valid = 1'b0; j2_valid = 1'b0;
        check("t4_jogada1", 32'(jogada1), 32'h3);
        check("t4_jogada2", 32'(jogada2), 32'h0);
        check("t4_tentativas", 32'(tentativas), 32'd0);
        check("t4_j2_ready", 32'(j2_ready), 32'd1);

        // novo_jogo during AVALIA with a hit pending.
        send_j2(3'b011);
        novo_jogo = 1'b1;
        tick();
        novo_jogo = 1'b0;
        tick();
        check("t5_fim", 32'(fim), 32'd0);
        check("t5_vencedor", 32'(vencedor), 32'd0);
        check("t5_j1_ready", 32'(j1_ready), 32'd1);
        check("t5_tentativas", 32'(tentativas), 32'd0);
        check("t5_jogada2", 32'(jogada2), 32'd0);

        // Asynchronous reset mid-game, observed before any clock edge.
        send_j1(3'b110);
        send_j2(3'b000);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t1_j1_ready", 32'(j1_ready), 32'd1);
        check("t1_j2_ready", 32'(j2_ready), 32'd0);
        check("t1_tentativas", 32'(tentativas), 32'd0);
        check("t1_jogada1", 32'(jogada1), 32'd0);
        check("t1_fim_venc", 32'({fim, vencedor}), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Randomized games against the reference model.
        for (int g = 0; g < 200; g++) begin
            secreto = W'($urandom_range(0, 7));
            acertou = -1;
            for (int i = 0; i < MAX_TENT; i++) begin
                palpite[i] = ($urandom_range(0, 3) == 0) ? secreto : W'($urandom_range(0, 7));
                if (acertou < 0 && palpite[i] == secreto) acertou = i;
            end
            n = (acertou >= 0) ? acertou + 1 : MAX_TENT;
            esperado.push_back('{venc: (acertou >= 0), tent: CW'(n)});

            repeat ($urandom_range(0, 3)) tick();
            check_ready_indep();
            send_j1(secreto);
            check_ready_indep();
            for (int i = 0; i < n; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                if ($urandom_range(0, 3) == 0) begin
                    j1_valid = 1'b1;
                    j1_dado  = ~secreto;
                end
                send_j2(palpite[i]);
                j1_valid = 1'b0;
            end
            espera = 0;
            while (!fim && espera < 10) begin
                tick();
                espera++;
            end
            check("rand_fim_reached", 32'(fim), 32'd1);
            check("rand_secret_kept", 32'(jogada1), 32'(secreto));
            check_ready_indep();
            tick();
            novo();
        end

        tick();
        check("sb_drained", 32'(esperado.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
